timing_counter: RTL

TIMING_COUNTER -- requirements
Module: timing_counter

---
 rtl/timing_counter.sv | 67 ++++++
 1 files changed

// File: rtl/timing_counter.sv
// timing_counter: video raster counter producing hCount/vCount with registered
// sync, data-enable and line/frame start strobes aligned to the counts.
module timing_counter #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int SYNC_POL = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] hCount,
    output logic [10:0] vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        dataEnable,
    output logic        lineStart,
    output logic        frameStart
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic POL = SYNC_POL != 0;

    logic        hWrap;
    logic [11:0] hNext;
    logic [10:0] vNext;

    always_comb begin
        hWrap = hCount == H_LAST;
        hNext = hWrap ? 12'd0 : hCount + 12'd1;
        vNext = !hWrap ? vCount : (vCount == V_LAST ? 11'd0 : vCount + 11'd1);
    end

    // Every output is decoded from the next counts so it lands on the same edge as them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hCount     <= H_LAST;
            vCount     <= V_LAST;
            hSync      <= !POL;
            vSync      <= !POL;
            dataEnable <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else if (enable) begin
            hCount     <= hNext;
            vCount     <= vNext;
            hSync      <= (hNext >= H_SS && hNext < H_SE) ? POL : !POL;
            vSync      <= (vNext >= V_SS && vNext < V_SE) ? POL : !POL;
            dataEnable <= hNext < H_ACT && vNext < V_ACT;
            lineStart  <= hWrap;
            frameStart <= hWrap && vNext == 11'd0;
        end
    end
endmodule
